// File: rtl/sifh_pkg.sv
// ----------------------------------------------------------------------------
// sifh_pkg
// Shared definitions for the SiFH acquisition scheduler.
//   - NP, PIXELS    : mirror Np and PIXEL_NUM_PER_RAM from parametersSiFH.vh
//   - ACQ_CYCLES    : acquisition window length in clocks
//   - FLUSH_CYCLES  : idle beats issued after ACQ to drain the SiFH_FSM pipe
//   - sifh_sched_state_t : scheduler frame state
// ----------------------------------------------------------------------------
package sifh_pkg;

    localparam int NP           = 10;    // Np
    localparam int PIXELS       = 4;     // PIXEL_NUM_PER_RAM
    localparam int ACQ_CYCLES   = 1024;
    localparam int FLUSH_CYCLES = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQ     = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_READOUT = 2'd3
    } sifh_sched_state_t;

endpackage

// File: rtl/sifh_acq_scheduler_if.sv
// ----------------------------------------------------------------------------
// sifh_acq_scheduler_if
// Bundles every non-clock signal of the acquisition scheduler.
//   control : start, abort (in)            busy, done, ev_count (out)
//   pixels  : pix_valid, pix_data (in)     pix_ready (out, one-hot grant)
//   SiFH    : fsm_ready (in)               fsm_wrEn, fsm_data, fsm_pix (out)
//   readout : rd_ready (in)                rd_valid, rd_addr (out)
// Modport 'slave' is the scheduler; 'master' is the surrounding front-end /
// SiFH_FSM / readout environment.
// ----------------------------------------------------------------------------
interface sifh_acq_scheduler_if #(
    parameter int PIXELS = sifh_pkg::PIXELS,
    parameter int NP     = sifh_pkg::NP,
    parameter int PW     = $clog2(PIXELS)
) ();

    logic                 start;
    logic                 abort;
    logic [PIXELS-1:0]    pix_valid;
    logic [PIXELS*NP-1:0] pix_data;
    logic [PIXELS-1:0]    pix_ready;
    logic                 fsm_ready;
    logic                 fsm_wrEn;
    logic [NP-1:0]        fsm_data;
    logic [PW-1:0]        fsm_pix;
    logic                 rd_valid;
    logic [PW-1:0]        rd_addr;
    logic                 rd_ready;
    logic                 busy;
    logic                 done;
    logic [15:0]          ev_count;

    modport slave (
        input  start, abort, pix_valid, pix_data, fsm_ready, rd_ready,
        output pix_ready, fsm_wrEn, fsm_data, fsm_pix, rd_valid, rd_addr,
               busy, done, ev_count
    );

    modport master (
        output start, abort, pix_valid, pix_data, fsm_ready, rd_ready,
        input  pix_ready, fsm_wrEn, fsm_data, fsm_pix, rd_valid, rd_addr,
               busy, done, ev_count
    );

endinterface

// File: rtl/sifh_rr_arbiter.sv
// ----------------------------------------------------------------------------
// sifh_rr_arbiter
// Combinational round-robin arbiter: rotate the request vector so that 'ptr'
// sits at bit 0, pick the lowest set bit, rotate the pick back.
//   req [N]  : request per requester
//   ptr [PW] : highest-priority requester this cycle
//   en       : gnt is forced to zero when low
//   gnt [N]  : one-hot grant or all zero
// N must be a power of two so index arithmetic wraps in PW bits.
// ----------------------------------------------------------------------------
module sifh_rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt
);

    logic [N-1:0] w_req_rot;
    logic [N-1:0] w_pick;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_req_rot = '0;
        for (int i = 0; i < N; i++) begin
            w_req_rot[i] = req[PW'(i) + ptr];
        end
    end

    // Two's-complement trick isolates the lowest set bit.
    assign w_pick = w_req_rot & (~w_req_rot + N'(1));

    always_comb begin
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            gnt[PW'(i) + ptr] = w_pick[i] & en;
        end
    end

endmodule

// File: rtl/sifh_acq_scheduler.sv
// ----------------------------------------------------------------------------
// sifh_acq_scheduler
// Shares one SiFH_FSM between PIXELS timestamp sources. A frame runs
// ACQ (round-robin grants, one beat per cycle forwarded with 1-cycle latency),
// then FLUSH (FLUSH_CYCLES empty beats), then READOUT (addresses 0..PIXELS-1
// offered to the peakResult reader), then pulses 'done'.
//   clk : rising-edge clock
//   res : asynchronous active-high reset
//   bus : sifh_acq_scheduler_if.slave, all handshake/control signals
// ----------------------------------------------------------------------------
module sifh_acq_scheduler #(
    parameter int PIXELS       = sifh_pkg::PIXELS,
    parameter int NP           = sifh_pkg::NP,
    parameter int ACQ_CYCLES   = sifh_pkg::ACQ_CYCLES,
    parameter int FLUSH_CYCLES = sifh_pkg::FLUSH_CYCLES
) (
    input logic                 clk,
    input logic                 res,
    sifh_acq_scheduler_if.slave bus
);

    import sifh_pkg::*;

    localparam int PW = $clog2(PIXELS);
    localparam int AW = $clog2(ACQ_CYCLES);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    localparam logic [AW-1:0] ACQ_LAST   = AW'(ACQ_CYCLES - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
    localparam logic [PW-1:0] ADDR_LAST  = PW'(PIXELS - 1);

    sifh_sched_state_t r_state;
    sifh_sched_state_t w_state_nxt;

    logic [AW-1:0]     r_acq_cnt;
    logic [FW-1:0]     r_flush_cnt;
    logic [PW-1:0]     r_rr_ptr;
    logic [PW-1:0]     r_rd_addr;
    logic [15:0]       r_ev_count;
    logic              r_fsm_wren;
    logic [NP-1:0]     r_fsm_data;
    logic [PW-1:0]     r_fsm_pix;
    logic              r_rd_valid;
    logic              r_busy;
    logic              r_done;

    logic [PIXELS-1:0] w_gnt;
    logic [PW-1:0]     w_gnt_idx;
    logic [NP-1:0]     w_gnt_data;
    logic              w_grant_en;
    logic              w_xfer;
    logic              w_start_ok;
    logic              w_rd_hs;
    logic              w_rd_last;

    // Abort suppresses the grant so a beat is never forwarded in that cycle.
    assign w_grant_en = (r_state == ST_ACQ) && bus.fsm_ready && !bus.abort;

    sifh_rr_arbiter #(
        .N  (PIXELS),
        .PW (PW)
    ) u_arb (
        .req (bus.pix_valid),
        .ptr (r_rr_ptr),
        .en  (w_grant_en),
        .gnt (w_gnt)
    );

    // The arbiter only grants asserted requests, so any grant is a transfer.
    assign w_xfer = |w_gnt;

    always_comb begin
        w_gnt_idx  = '0;
        w_gnt_data = '0;
        for (int i = 0; i < PIXELS; i++) begin
            if (w_gnt[i]) begin
                w_gnt_idx  = PW'(i);
                w_gnt_data = bus.pix_data[i*NP +: NP];
            end
        end
    end

    assign w_start_ok = (r_state == ST_IDLE) && bus.start && !bus.abort;
    assign w_rd_hs    = r_rd_valid && bus.rd_ready;
    assign w_rd_last  = w_rd_hs && (r_rd_addr == ADDR_LAST);

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and processes cannot race each other.
    always_ff @(posedge clk or posedge res) begin
        if (res) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:    if (bus.start)                 w_state_nxt = ST_ACQ;
            ST_ACQ:     if (r_acq_cnt == ACQ_LAST)     w_state_nxt = ST_FLUSH;
            ST_FLUSH:   if (r_flush_cnt == FLUSH_LAST) w_state_nxt = ST_READOUT;
            ST_READOUT: if (w_rd_last)                 w_state_nxt = ST_IDLE;
            default:                                   w_state_nxt = ST_IDLE;
        endcase
        if (bus.abort) w_state_nxt = ST_IDLE;
    end

    // ---------------- counters and registered outputs ----------------
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_acq_cnt   <= '0;
            r_flush_cnt <= '0;
            r_rr_ptr    <= '0;
            r_rd_addr   <= '0;
            r_ev_count  <= '0;
            r_fsm_wren  <= 1'b0;
            r_fsm_data  <= '0;
            r_fsm_pix   <= '0;
            r_rd_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_start_ok)              r_acq_cnt <= '0;
            else if (r_state == ST_ACQ)  r_acq_cnt <= r_acq_cnt + AW'(1);

            r_flush_cnt <= (r_state == ST_FLUSH) ? r_flush_cnt + FW'(1) : '0;

            // Pointer moves just past the winner; PIXELS is a power of two so
            // the increment wraps by itself.
            if (w_start_ok)   r_rr_ptr <= '0;
            else if (w_xfer)  r_rr_ptr <= w_gnt_idx + PW'(1);

            if (w_start_ok)
                r_ev_count <= '0;
            else if (w_xfer && (r_ev_count != 16'hFFFF))
                r_ev_count <= r_ev_count + 16'd1;

            // Idle beats (including the whole FLUSH period) carry zero data.
            r_fsm_wren <= w_xfer;
            r_fsm_data <= w_xfer ? w_gnt_data : '0;
            r_fsm_pix  <= w_xfer ? w_gnt_idx  : '0;

            // Address restarts at 0 on every entry into READOUT.
            if (w_state_nxt != ST_READOUT) r_rd_addr <= '0;
            else if (w_rd_hs)              r_rd_addr <= r_rd_addr + PW'(1);

            r_rd_valid <= (w_state_nxt == ST_READOUT);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= w_rd_last && !bus.abort;
        end
    end

    assign bus.pix_ready = w_gnt;
    assign bus.fsm_wrEn  = r_fsm_wren;
    assign bus.fsm_data  = r_fsm_data;
    assign bus.fsm_pix   = r_fsm_pix;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_addr   = r_rd_addr;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.ev_count  = r_ev_count;

endmodule

// File: tb/tb_sifh_acq_scheduler.sv
// ----------------------------------------------------------------------------
// tb_sifh_acq_scheduler
// Random and directed stimulus against a frame-level reference model. The
// driver pushes expected beats / done pulses (tagged with the cycle they must
// appear in) into queues; an independent negedge monitor pops and compares.
// ----------------------------------------------------------------------------
module tb_sifh_acq_scheduler;

    localparam int P   = 4;
    localparam int NPW = 10;
    localparam int A   = 64;
    localparam int F   = 4;
    localparam logic [P-1:0] ALL = '1;

    logic clk = 1'b0;
    logic res = 1'b0;
    always #5 clk = ~clk;

    sifh_acq_scheduler_if #(.PIXELS(P), .NP(NPW)) bus ();

    sifh_acq_scheduler #(
        .PIXELS       (P),
        .NP           (NPW),
        .ACQ_CYCLES   (A),
        .FLUSH_CYCLES (F)
    ) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    typedef struct { int cyc; int pix; int data; } beat_t;

    beat_t q_beat[$];
    int    q_done[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;

    // Reference model: frame time since ACQ entry, pointer, counters.
    bit m_active = 0;
    int m_t = 0, m_ptr = 0, m_ev = 0, m_rd = 0;

    // Expectations for the current cycle, refreshed by the driver.
    logic [P-1:0] exp_gnt = '0;
    logic         exp_busy = 1'b0, exp_rdv = 1'b0, exp_flush = 1'b0;
    int           exp_rdaddr = 0, exp_ev = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [P*NPW-1:0] rand_data();
        logic [P*NPW-1:0] d;
        for (int i = 0; i < P; i++) d[i*NPW +: NPW] = NPW'($urandom_range(0, 1023));
        return d;
    endfunction

    function automatic bit in_readout();
        return m_active && (m_t >= A + F);
    endfunction

    task automatic m_reset();
        m_active = 0; m_t = 0; m_ptr = 0; m_ev = 0; m_rd = 0;
        q_beat.delete(); q_done.delete();
        exp_gnt = '0; exp_busy = 1'b0; exp_rdv = 1'b0; exp_flush = 1'b0;
        exp_rdaddr = 0; exp_ev = 0;
    endtask

    // Drive one cycle of inputs and advance the model by one cycle.
    task automatic apply(input logic [P-1:0] v, input logic [P*NPW-1:0] d,
                         input logic fr, input logic rr, input logic st, input logic ab);
        bit in_acq, in_flush, in_rd, hs;
        int g;
        bus.pix_valid = v;
        bus.pix_data  = d;
        bus.fsm_ready = fr;
        bus.rd_ready  = rr;
        bus.start     = st;
        bus.abort     = ab;

        in_acq   = m_active && (m_t < A);
        in_flush = m_active && (m_t >= A) && (m_t < A + F);
        in_rd    = in_readout();

        exp_busy   = m_active;
        exp_rdv    = in_rd;
        exp_rdaddr = m_rd;
        exp_ev     = m_ev;
        exp_flush  = in_flush;

        g = -1;
        if (in_acq && fr && !ab)
            for (int k = 0; k < P; k++)
                if (g < 0 && v[(m_ptr + k) % P]) g = (m_ptr + k) % P;
        exp_gnt = '0;
        if (g >= 0) begin
            exp_gnt[g] = 1'b1;
            q_beat.push_back('{cyc + 1, g, int'(d[g*NPW +: NPW])});
            m_ptr = (g + 1) % P;
            if (m_ev < 65535) m_ev++;
        end

        hs = in_rd && rr;
        if (hs && !ab && m_rd == P - 1) q_done.push_back(cyc + 1);

        if (ab) begin
            m_active = 0;
        end else if (!m_active) begin
            if (st) begin
                m_active = 1; m_t = 0; m_ptr = 0; m_ev = 0; m_rd = 0;
            end
        end else if (in_rd) begin
            if (hs) begin
                if (m_rd == P - 1) m_active = 0;
                else               m_rd++;
            end
        end else begin
            m_t++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    bit    mon_we, mon_done;
    beat_t mon_b;

    always @(negedge clk) begin
        check("pix_ready", 32'(bus.pix_ready), 32'(exp_gnt));
        check("busy", 32'(bus.busy), 32'(exp_busy));
        check("rd_valid", 32'(bus.rd_valid), 32'(exp_rdv));
        if (exp_rdv) check("rd_addr", 32'(bus.rd_addr), 32'(exp_rdaddr));
        check("ev_count", 32'(bus.ev_count), 32'(exp_ev));

        while (q_beat.size() > 0 && q_beat[0].cyc < cyc) void'(q_beat.pop_front());
        mon_we = (q_beat.size() > 0) && (q_beat[0].cyc == cyc);
        check("fsm_wrEn", 32'(bus.fsm_wrEn), 32'(mon_we));
        if (mon_we) begin
            mon_b = q_beat.pop_front();
            if (bus.fsm_wrEn) begin
                check("fsm_data", 32'(bus.fsm_data), 32'(mon_b.data));
                check("fsm_pix", 32'(bus.fsm_pix), 32'(mon_b.pix));
            end
        end else if (exp_flush) begin
            check("fsm_data_flush", 32'(bus.fsm_data), 32'd0);
        end

        while (q_done.size() > 0 && q_done[0] < cyc) void'(q_done.pop_front());
        mon_done = (q_done.size() > 0) && (q_done[0] == cyc);
        check("done", 32'(bus.done), 32'(mon_done));
        if (mon_done) void'(q_done.pop_front());
    end

    // ---------------- stimulus ----------------
    task automatic run_random_frame();
        int n;
        apply(P'($urandom_range(0, (1 << P) - 1)), rand_data(), 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        n = 0;
        while (m_active && n < 2000) begin
            apply(P'($urandom_range(0, (1 << P) - 1)), rand_data(),
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) == 0));
            tick();
            n++;
        end
        check("random_frame_bound", 32'(m_active), 32'd0);
        repeat (2) begin
            apply(P'($urandom_range(0, (1 << P) - 1)), rand_data(), 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
    endtask

    logic [P*NPW-1:0] d108;
    int               rd_k;
    int               n_guard;

    initial begin
        apply('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 res = 1'b1;
        #1;
        check("rst_pix_ready", 32'(bus.pix_ready), 32'd0);
        check("rst_fsm_wrEn", 32'(bus.fsm_wrEn), 32'd0);
        check("rst_fsm_data", 32'(bus.fsm_data), 32'd0);
        check("rst_fsm_pix", 32'(bus.fsm_pix), 32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_ev_count", 32'(bus.ev_count), 32'd0);
        tick();
        tick();
        res = 1'b0;
        tick();

        // Single pixel, then backpressure, last-cycle transfer, toggled readout.
        apply('0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        repeat (2) begin
            apply('0, rand_data(), 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        d108 = rand_data();
        d108[2*NPW +: NPW] = NPW'(108);
        apply(4'b0100, d108, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 check("single_pix_ready", 32'(bus.pix_ready), 32'b0100);
        tick();
        check("single_wrEn", 32'(bus.fsm_wrEn), 32'd1);
        check("single_data", 32'(bus.fsm_data), 32'd108);
        check("single_pix", 32'(bus.fsm_pix), 32'd2);
        check("single_ev_count", 32'(bus.ev_count), 32'd1);

        rd_k = 0;
        n_guard = 0;
        while (m_active && n_guard < 500) begin
            if (in_readout()) begin
                apply(ALL, rand_data(), 1'b1, (rd_k % 2 == 0), 1'b0, 1'b0);
                rd_k++;
            end else begin
                apply(ALL, rand_data(), !(n_guard >= 5 && n_guard < 10), 1'b0, 1'b0, 1'b0);
            end
            tick();
            n_guard++;
        end
        check("frame1_bound", 32'(m_active), 32'd0);
        apply('0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();

        // Round-robin with every pixel requesting and no backpressure.
        apply(ALL, rand_data(), 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < A; k++) begin
            apply(ALL, rand_data(), 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        check("rr_ev_count_flush_entry", 32'(bus.ev_count), 32'(A));
        n_guard = 0;
        while (m_active && n_guard < 100) begin
            apply(ALL, rand_data(), 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
            n_guard++;
        end
        check("frame2_bound", 32'(m_active), 32'd0);

        // Start ignored during ACQ, abort in FLUSH, start+abort in IDLE.
        apply(ALL, rand_data(), 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < A + 1; k++) begin
            apply(ALL, rand_data(), 1'b1, 1'b1, (k == 3), 1'b0);
            tick();
        end
        apply(ALL, rand_data(), 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        repeat (4) begin
            apply(ALL, rand_data(), 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        apply(ALL, rand_data(), 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check("start_abort_busy", 32'(bus.busy), 32'd0);
        apply(ALL, rand_data(), 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("start_abort_idle", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of READOUT.
        apply(ALL, rand_data(), 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        n_guard = 0;
        while (!(in_readout() && m_rd == 2) && n_guard < 200) begin
            apply(ALL, rand_data(), 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
            n_guard++;
        end
        check("reach_readout", 32'(in_readout()), 32'd1);
        #1 res = 1'b1;
        m_reset();
        #1;
        check("arst_pix_ready", 32'(bus.pix_ready), 32'd0);
        check("arst_fsm_wrEn", 32'(bus.fsm_wrEn), 32'd0);
        check("arst_fsm_data", 32'(bus.fsm_data), 32'd0);
        check("arst_fsm_pix", 32'(bus.fsm_pix), 32'd0);
        check("arst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("arst_rd_addr", 32'(bus.rd_addr), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_ev_count", 32'(bus.ev_count), 32'd0);
        apply('0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        res = 1'b0;
        tick();

        for (int f = 0; f < 15; f++) run_random_frame();

        check("beats_pending", 32'(q_beat.size()), 32'd0);
        check("done_pending", 32'(q_done.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sifh_acq_scheduler.md
# sifh_acq_scheduler

Acquisition scheduler for the SiFH histogram FSM: it shares one SiFH_FSM instance between `PIXELS` pixel timestamp sources. During a frame it grants pixels round-robin and forwards one accepted timestamp per cycle as a `wrEn`/`data` beat. After the frame it drives a flush period, then sequences the per-pixel peak-result readout. It sits between the TDC/pixel front-end and SiFH_FSM.

## Interface
- `PIXELS`, 4: number of requesters; equals `PIXEL_NUM_PER_RAM`; power of two, 2..16.
- `NP`, 10: timestamp width; equals `Np`.
- `ACQ_CYCLES`, 1024: length of the ACQ window in clocks; at least 2.
- `FLUSH_CYCLES`, 4: idle beats issued after ACQ to drain the SiFH_FSM pipeline; at least 1.
- `PW`, $clog2(PIXELS): pixel-index width.
- `clk` in 1: single clock; all logic is rising-edge.
- `res` in 1: reset, asynchronous, active-high.
- `start` in 1: single-cycle frame start; honoured only in IDLE.
- `abort` in 1: return to IDLE from any state.
- `pix_valid` in PIXELS: request per pixel; bit i belongs to pixel i.
- `pix_data` in PIXELS*NP: timestamps; pixel i occupies slice [i*NP +: NP].
- `pix_ready` out PIXELS: one-hot grant (or all zero).
- `fsm_ready` in 1: SiFH_FSM can accept a beat this cycle.
- `fsm_wrEn` out 1: beat valid to SiFH_FSM.
- `fsm_data` out NP: timestamp to SiFH_FSM.
- `fsm_pix` out PW: pixel index of the beat.
- `rd_valid` out 1: readout address valid.
- `rd_addr` out PW: pixel index to read from `peakResult`.
- `rd_ready` in 1: downstream consumes the readout address.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a frame's readout completes.
- `ev_count` out 16: beats forwarded in the current frame; saturates at 0xFFFF.

## Operation
- States: IDLE, ACQ, FLUSH, READOUT.
- IDLE
  - `start`: go to ACQ; clear `acq_cnt`, `ev_count` and `rr_ptr`.
- ACQ
  - `pix_ready` is one-hot on the first set `pix_valid` bit searching from `rr_ptr` upward with wrap-around.
  - `pix_ready` is combinational and gated by `fsm_ready`; it is all zero if no request is valid or `fsm_ready` is 0.
  - A transfer happens when `pix_valid[i] & pix_ready[i]`.
  - On a transfer, `rr_ptr` becomes (i+1) mod PIXELS and `ev_count` increments (saturating).
  - `acq_cnt` increments every cycle in ACQ.
  - When `acq_cnt == ACQ_CYCLES-1`, go to FLUSH. A transfer in that same cycle is accepted.
- FLUSH
  - `pix_ready` is 0.
  - Drive `fsm_wrEn`=0 and `fsm_data`=0 for `FLUSH_CYCLES` cycles, then go to READOUT.
- READOUT
  - `rd_valid`=1 and `rd_addr` starts at 0.
  - On `rd_valid & rd_ready`, increment `rd_addr`.
  - When address PIXELS-1 is consumed: pulse `done`, go to IDLE, clear `rd_addr`.
- `abort`
  - Has priority over all other transitions: next state is IDLE.
  - A transfer in the abort cycle is not forwarded: `pix_ready` is 0 when `abort`=1.
  - `ev_count` holds its value.
- `start` outside IDLE is ignored.
- `start` and `abort` together in IDLE: `abort` wins and the block stays in IDLE.
- Requesters keep `pix_data` stable while `pix_valid` is high and not yet granted. The scheduler does not check this.

## Timing
- Reset values: state IDLE; `pix_ready`, `fsm_wrEn`, `rd_valid`, `busy` and `done` all 0; `fsm_data`, `fsm_pix`, `rd_addr` and `ev_count` all 0; `rr_ptr` is 0.
- Forward latency is 1 cycle: a transfer at edge n gives `fsm_wrEn`=1 with that data and index after edge n+1.
- `fsm_wrEn` is registered. It is 0 after any cycle without a transfer.
- `busy` and `rd_valid` are registered state decodes.
  - `busy` rises the cycle after `start` is accepted.
  - `busy` falls the cycle after the last readout handshake, in the same cycle `done` is high.
- A full frame with `rd_ready` held at 1 takes 1 + ACQ_CYCLES + FLUSH_CYCLES + PIXELS cycles from `start` to `done`.
- Reset asserted mid-frame returns the block to the reset values immediately (asynchronous); a partial frame is never resumed.

## Structure
- Shared package `sifh_pkg`:
  - state enum `sifh_sched_state_t`;
  - constants `NP`, `PIXELS`, `ACQ_CYCLES` and `FLUSH_CYCLES`, mapped from `parametersSiFH.vh` (`Np`, `PIXEL_NUM_PER_RAM`).
- One sub-module: `sifh_rr_arbiter`, a combinational rotate-priority-rotate one-hot grant with inputs `req`, `ptr` and `en` and output `gnt`.
- The FSM, counters and output registers live in the top.

## Test plan
- **Single pixel:** PIXELS=4; `start`; pixel 2 valid with data 108 in cycle 3 of ACQ -> `pix_ready`=4'b0100 in that cycle; `fsm_wrEn`=1, `fsm_data`=108, `fsm_pix`=2 on the next cycle; `ev_count`=1.
- **Round-robin fairness:** all four pixels valid continuously, `fsm_ready`=1 -> grants in order 0,1,2,3,0,…; `ev_count`=ACQ_CYCLES at FLUSH entry.
- **Backpressure:** all pixels valid, `fsm_ready`=0 for 5 cycles -> `pix_ready`=0 and no beats during those cycles; the pointer is unchanged and the grant order resumes where it stopped.
- **Boundary:** transfer in the last ACQ cycle -> beat forwarded; then exactly FLUSH_CYCLES beats with `fsm_wrEn`=0; then `rd_addr` 0..3 with `rd_ready` toggling 1,0,1,… and `done` on the last handshake.
- **Abort and ignored start:** `abort` in FLUSH -> IDLE next cycle, `done` stays 0; `start` during ACQ -> no restart (`acq_cnt` continues); `start` together with `abort` in IDLE -> block stays in IDLE.
- **Reset mid-READOUT:** assert `res` mid-READOUT -> every output returns to its reset value without waiting for a clock edge; a following `start` runs a clean frame.
